teclado_clave: RTL and testbench
================================

Name: teclado_clave

Overview:
- Keypad PIN entry front end. Collects decimal key presses and assembles a 4-digit BCD PIN.
- Delivers the PIN to the parking access controller on its 16-bit `clave_ingresada` input, together with a one-cycle `clave_lista` strobe.
- Sits between the physical keypad scanner and the access controller. It produces the PIN that the controller checks.

Parameters:
- TIMEOUT_CYCLES, 1000, idle cycles with no key press (while `digitos_cnt` > 0) before a partial entry is discarded.
- TIMER_W, 16, width of the inactivity counter; must satisfy 2^TIMER_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- habilitar  in  1  entry allowed (vehicle present at gate), level.
- tecla_valida  in  1  one-cycle key strobe from the keypad scanner.
- tecla  in  4  key code, sampled only when tecla_valida=1: 0x0-0x9 digit, 0xA borrar (clear), 0xB enter; 0xC-0xF ignored.
- clave_ingresada  out  16  last delivered PIN, BCD, first digit in [15:12].
- clave_lista  out  1  one-cycle pulse: clave_ingresada holds a new PIN.
- digitos_cnt  out  3  digits captured so far, 0..4.
- error_entrada  out  1  one-cycle pulse on a rejected or aborted entry.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, internal shift register=0, digitos_cnt=0, timer=0.
  - clave_ingresada=16'h0000, clave_lista=0, error_entrada=0.
  - A reset mid-entry discards the partial PIN immediately.
- FSM states: IDLE, CAPTURA, ENTREGA. All transitions occur on the rising clock edge.
- IDLE:
  - Keys are ignored.
  - habilitar=1 → CAPTURA, with shift register, digitos_cnt and timer cleared.
- CAPTURA, digit key:
  - If digitos_cnt<4: shreg <= {shreg[11:0], tecla}, digitos_cnt+1, timer cleared.
  - If digitos_cnt==4: digit ignored, error_entrada pulses, shreg and count unchanged.
- CAPTURA, borrar: shreg=0, digitos_cnt=0, timer cleared, no error pulse.
- CAPTURA, enter with digitos_cnt==4:
  - clave_ingresada <= shreg and clave_lista=1 on the same edge, so both are visible in the cycle after the strobe (latency 1).
  - Go to ENTREGA.
- CAPTURA, enter with digitos_cnt<4: error_entrada pulses; shreg and count cleared; clave_ingresada unchanged.
- CAPTURA, codes 0xC-0xF: no effect, timer not cleared.
- ENTREGA:
  - Lasts exactly one cycle; keys presented in this cycle are ignored.
  - clave_lista returns to 0.
  - shreg and count cleared.
  - Then → CAPTURA if habilitar=1, else IDLE.
- Timeout:
  - In CAPTURA with digitos_cnt>0 and no valid key, the timer increments each cycle.
  - When timer reaches TIMEOUT_CYCLES-1: shreg and count cleared, error_entrada pulses, timer reset.
  - The timer does not run while digitos_cnt==0.
- habilitar falls in CAPTURA:
  - → IDLE, partial entry cleared.
  - error_entrada pulses if digitos_cnt>0.
  - Takes priority over a key strobe in the same cycle.
- Priority within one CAPTURA cycle: habilitar=0 > key strobe > timeout expiry. A key in the expiry cycle is processed normally and the timer clears.
- clave_ingresada is held stable between deliveries; it changes only on a successful enter or on reset.
- clave_lista and error_entrada are registered, never asserted in the same cycle, and each lasts exactly one cycle.
- No BCD range check beyond the key decode: codes ≥0xA are never shifted in.

Test Plan:
- Reset, then habilitar=1; keys 1,2,3,4,enter → clave_ingresada=16'h1234 and clave_lista=1 for exactly one cycle, one cycle after the enter strobe; digitos_cnt returns to 0.
- Keys 5,6,enter → error_entrada one-cycle pulse, clave_ingresada stays 16'h1234, no clave_lista.
- Keys 9,8,7,6,5,enter → 5th digit gives error_entrada pulse; delivered PIN 16'h9876.
- Keys 1,2,borrar,3,4,5,6,enter → 16'h3456, no error pulse. Then keys 7,8 followed by TIMEOUT_CYCLES idle cycles → error_entrada pulse, digitos_cnt=0.
- Keys 1,2,3 then habilitar=0 together with a digit strobe → IDLE, error_entrada pulse, digit ignored. Further keys ignored until habilitar=1.
- Keys 4,3 then reset asserted low mid-cycle → all outputs 0 asynchronously. After release, clave_ingresada=16'h0000 and state=IDLE.

Source files
------------

// File: rtl/teclado_clave.sv
// Keypad PIN entry: collects four BCD digits and delivers them to the access
// controller with a one-cycle clave_lista strobe; aborted entries pulse error_entrada.
module teclado_clave #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TIMER_W        = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        habilitar,
  input  logic        tecla_valida,
  input  logic [3:0]  tecla,
  output logic [15:0] clave_ingresada,
  output logic        clave_lista,
  output logic [2:0]  digitos_cnt,
  output logic        error_entrada,
  output logic [1:0]  estado_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURA = 2'd1,
    ENTREGA = 2'd2
  } estado_t;

  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES - 1);

  estado_t              estado;
  logic [15:0]          shreg;
  logic [TIMER_W-1:0]   timer;
  logic                 es_digito, es_borrar, es_enter;

  // Handshake: tecla_valida is a one-cycle strobe with no ready; the block
  // accepts every strobe and simply ignores keys in states that do not use them.
  assign es_digito  = tecla_valida && (tecla <= 4'h9);
  assign es_borrar  = tecla_valida && (tecla == 4'hA);
  assign es_enter   = tecla_valida && (tecla == 4'hB);
  assign estado_dbg = estado;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado          <= IDLE;
      shreg           <= 16'h0000;
      digitos_cnt     <= 3'd0;
      timer           <= '0;
      clave_ingresada <= 16'h0000;
      clave_lista     <= 1'b0;
      error_entrada   <= 1'b0;
    end else begin
      clave_lista   <= 1'b0;
      error_entrada <= 1'b0;
      case (estado)
        IDLE: begin
          if (habilitar) begin
            estado      <= CAPTURA;
            shreg       <= 16'h0000;
            digitos_cnt <= 3'd0;
            timer       <= '0;
          end
        end
        CAPTURA: begin
          if (!habilitar) begin
            estado      <= IDLE;
            shreg       <= 16'h0000;
            digitos_cnt <= 3'd0;
            timer       <= '0;
            if (digitos_cnt != 3'd0) error_entrada <= 1'b1;
          end else if (es_digito) begin
            timer <= '0;
            if (digitos_cnt < 3'd4) begin
              shreg       <= {shreg[11:0], tecla};
              digitos_cnt <= digitos_cnt + 3'd1;
            end else begin
              error_entrada <= 1'b1;
            end
          end else if (es_borrar) begin
            shreg       <= 16'h0000;
            digitos_cnt <= 3'd0;
            timer       <= '0;
          end else if (es_enter) begin
            timer <= '0;
            if (digitos_cnt == 3'd4) begin
              clave_ingresada <= shreg;
              clave_lista     <= 1'b1;
              estado          <= ENTREGA;
            end else begin
              error_entrada <= 1'b1;
              shreg         <= 16'h0000;
              digitos_cnt   <= 3'd0;
            end
          end else if (digitos_cnt != 3'd0) begin
            // Codes 0xC-0xF land here too: they count as inactivity.
            if (timer == TIMER_MAX) begin
              shreg         <= 16'h0000;
              digitos_cnt   <= 3'd0;
              timer         <= '0;
              error_entrada <= 1'b1;
            end else begin
              timer <= timer + TIMER_W'(1);
            end
          end
        end
        ENTREGA: begin
          shreg       <= 16'h0000;
          digitos_cnt <= 3'd0;
          timer       <= '0;
          estado      <= habilitar ? CAPTURA : IDLE;
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_teclado_clave.sv
// Bench for teclado_clave: directed scenarios plus randomized traffic checked
// against a digit-queue reference model.
module tb_teclado_clave;

  localparam int TOUT = 24;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        habilitar = 1'b0;
  logic        tecla_valida = 1'b0;
  logic [3:0]  tecla = 4'h0;
  logic [15:0] clave_ingresada;
  logic        clave_lista;
  logic [2:0]  digitos_cnt;
  logic        error_entrada;
  logic [1:0]  estado_dbg;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [3:0]  m_q[$];
  logic [15:0] m_pin;
  logic        m_active, m_deliver, m_lista, m_err;
  int          m_idle;
  logic [15:0] exp_q[$];

  teclado_clave #(.TIMEOUT_CYCLES(TOUT), .TIMER_W(16)) dut (
    .clock(clock), .reset(reset), .habilitar(habilitar),
    .tecla_valida(tecla_valida), .tecla(tecla),
    .clave_ingresada(clave_ingresada), .clave_lista(clave_lista),
    .digitos_cnt(digitos_cnt), .error_entrada(error_entrada),
    .estado_dbg(estado_dbg)
  );

  // Clock / reset block
  always #5 clock = ~clock;

  task automatic model_reset();
    m_q.delete();
    m_pin = 16'h0000;
    m_active = 1'b0; m_deliver = 1'b0;
    m_lista = 1'b0;  m_err = 1'b0;
    m_idle = 0;
  endtask

  function automatic logic [1:0] m_state();
    if (m_deliver) return 2'd2;
    if (m_active)  return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_step(input logic hab, input logic v, input logic [3:0] k);
    m_lista = 1'b0;
    m_err   = 1'b0;
    if (m_deliver) begin
      m_deliver = 1'b0; m_q.delete(); m_idle = 0; m_active = hab;
    end else if (!m_active) begin
      if (hab) begin m_active = 1'b1; m_q.delete(); m_idle = 0; end
    end else if (!hab) begin
      if (m_q.size() > 0) m_err = 1'b1;
      m_q.delete(); m_active = 1'b0; m_idle = 0;
    end else if (v && k < 4'hA) begin
      if (m_q.size() < 4) m_q.push_back(k); else m_err = 1'b1;
      m_idle = 0;
    end else if (v && k == 4'hA) begin
      m_q.delete(); m_idle = 0;
    end else if (v && k == 4'hB) begin
      if (m_q.size() == 4) begin
        m_pin = {m_q[0], m_q[1], m_q[2], m_q[3]};
        m_lista = 1'b1; m_deliver = 1'b1;
        exp_q.push_back(m_pin);
      end else begin
        m_err = 1'b1; m_q.delete();
      end
      m_idle = 0;
    end else if (m_q.size() > 0) begin
      m_idle++;
      if (m_idle == TOUT) begin m_q.delete(); m_err = 1'b1; m_idle = 0; end
    end
  endtask

  // Driver: apply inputs, clock once, advance the model, sample 1 ns later.
  task automatic tick(input logic hab, input logic v, input logic [3:0] k);
    habilitar = hab; tecla_valida = v; tecla = k;
    @(posedge clock);
    model_step(hab, v, k);
    #1;
    tecla_valida = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (clave_ingresada !== 16'h0000 || clave_lista !== 1'b0 || error_entrada !== 1'b0 ||
        digitos_cnt !== 3'd0 || estado_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset got clave=%h lista=%b err=%b cnt=%0d st=%0d exp all zero",
               clave_ingresada, clave_lista, error_entrada, digitos_cnt, estado_dbg);
    end
  endtask

  task automatic test_pin_ok();
    logic [3:0] ks[] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hB};
    tick(1'b1, 1'b0, 4'h0);
    foreach (ks[i]) begin
      tick(1'b1, 1'b1, ks[i]);
      checks++;
      if (digitos_cnt !== 3'(m_q.size()) || clave_lista !== m_lista) begin
        errors++;
        $display("FAIL pin_ok_step%0d got cnt=%0d lista=%b exp cnt=%0d lista=%b",
                 i, digitos_cnt, clave_lista, m_q.size(), m_lista);
      end
    end
    checks++;
    if (clave_ingresada !== 16'h1234 || clave_lista !== 1'b1) begin
      errors++;
      $display("FAIL pin_ok_deliver got clave=%h lista=%b exp 1234 1", clave_ingresada, clave_lista);
    end
    tick(1'b1, 1'b1, 4'h9);  // ignored during delivery cycle
    checks++;
    if (clave_lista !== 1'b0 || digitos_cnt !== 3'd0 || estado_dbg !== 2'd1) begin
      errors++;
      $display("FAIL pin_ok_after got lista=%b cnt=%0d st=%0d exp 0 0 1",
               clave_lista, digitos_cnt, estado_dbg);
    end
    exp_q.delete();
  endtask

  task automatic test_short_pin();
    logic [3:0] ks[] = '{4'h5, 4'h6, 4'hB};
    foreach (ks[i]) tick(1'b1, 1'b1, ks[i]);
    checks++;
    if (error_entrada !== 1'b1 || clave_lista !== 1'b0 || clave_ingresada !== 16'h1234 ||
        digitos_cnt !== 3'd0) begin
      errors++;
      $display("FAIL short_pin got err=%b lista=%b clave=%h cnt=%0d exp 1 0 1234 0",
               error_entrada, clave_lista, clave_ingresada, digitos_cnt);
    end
    tick(1'b1, 1'b0, 4'h0);
    checks++;
    if (error_entrada !== 1'b0) begin
      errors++;
      $display("FAIL short_pin_pulse got err=%b exp 0", error_entrada);
    end
  endtask

  task automatic test_extra_digit();
    logic [3:0] ks[] = '{4'h9, 4'h8, 4'h7, 4'h6, 4'h5, 4'hB};
    int errs_seen = 0;
    foreach (ks[i]) begin
      tick(1'b1, 1'b1, ks[i]);
      if (error_entrada === 1'b1) errs_seen++;
      checks++;
      if (error_entrada !== m_err || digitos_cnt !== 3'(m_q.size())) begin
        errors++;
        $display("FAIL extra_digit_step%0d got err=%b cnt=%0d exp err=%b cnt=%0d",
                 i, error_entrada, digitos_cnt, m_err, m_q.size());
      end
    end
    checks++;
    if (clave_ingresada !== 16'h9876 || clave_lista !== 1'b1 || errs_seen != 1) begin
      errors++;
      $display("FAIL extra_digit_deliver got clave=%h lista=%b errs=%0d exp 9876 1 1",
               clave_ingresada, clave_lista, errs_seen);
    end
    tick(1'b1, 1'b0, 4'h0);
    exp_q.delete();
  endtask

  task automatic test_borrar_timeout();
    logic [3:0] ks[] = '{4'h1, 4'h2, 4'hA, 4'h3, 4'h4, 4'h5, 4'h6, 4'hB};
    int errs_seen = 0;
    foreach (ks[i]) begin
      tick(1'b1, 1'b1, ks[i]);
      if (error_entrada === 1'b1) errs_seen++;
    end
    checks++;
    if (clave_ingresada !== 16'h3456 || clave_lista !== 1'b1 || errs_seen != 0) begin
      errors++;
      $display("FAIL borrar got clave=%h lista=%b errs=%0d exp 3456 1 0",
               clave_ingresada, clave_lista, errs_seen);
    end
    tick(1'b1, 1'b0, 4'h0);
    tick(1'b1, 1'b1, 4'h7);
    tick(1'b1, 1'b1, 4'h8);
    for (int c = 1; c <= TOUT; c++) begin
      tick(1'b1, 1'b0, 4'h0);
      checks++;
      if (error_entrada !== (c == TOUT) || digitos_cnt !== ((c == TOUT) ? 3'd0 : 3'd2)) begin
        errors++;
        $display("FAIL timeout_cycle%0d got err=%b cnt=%0d exp err=%b", c,
                 error_entrada, digitos_cnt, (c == TOUT));
      end
    end
    exp_q.delete();
  endtask

  task automatic test_hab_drop();
    tick(1'b1, 1'b1, 4'h1);
    tick(1'b1, 1'b1, 4'h2);
    tick(1'b1, 1'b1, 4'h3);
    tick(1'b0, 1'b1, 4'h4);
    checks++;
    if (error_entrada !== 1'b1 || digitos_cnt !== 3'd0 || estado_dbg !== 2'd0) begin
      errors++;
      $display("FAIL hab_drop got err=%b cnt=%0d st=%0d exp 1 0 0",
               error_entrada, digitos_cnt, estado_dbg);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, 4'(i + 5));
      checks++;
      if (digitos_cnt !== 3'd0 || error_entrada !== 1'b0 || estado_dbg !== 2'd0) begin
        errors++;
        $display("FAIL hab_idle_keys%0d got cnt=%0d err=%b st=%0d exp 0 0 0",
                 i, digitos_cnt, error_entrada, estado_dbg);
      end
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 1'b0, 4'h0);
    tick(1'b1, 1'b1, 4'h4);
    tick(1'b1, 1'b1, 4'h3);
    #3 reset = 1'b0;
    #1;
    checks++;
    if (clave_ingresada !== 16'h0000 || digitos_cnt !== 3'd0 || estado_dbg !== 2'd0 ||
        clave_lista !== 1'b0 || error_entrada !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async got clave=%h cnt=%0d st=%0d exp 0 0 0",
               clave_ingresada, digitos_cnt, estado_dbg);
    end
    habilitar = 1'b0;
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    model_reset();
    tick(1'b0, 1'b0, 4'h0);
    checks++;
    if (clave_ingresada !== 16'h0000 || estado_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_release got clave=%h st=%0d exp 0 0", clave_ingresada, estado_dbg);
    end
  endtask

  task automatic test_random();
    logic hab, v;
    logic [3:0] k;
    exp_q.delete();
    for (int i = 0; i < 1500; i++) begin
      hab = ($urandom_range(0, 39) != 0);
      v   = (i < 700) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
      k   = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
      tick(hab, v, k);
      checks++;
      if (digitos_cnt !== 3'(m_q.size()) || clave_lista !== m_lista ||
          error_entrada !== m_err || clave_ingresada !== m_pin || estado_dbg !== m_state()) begin
        errors++;
        $display("FAIL random_cycle%0d got cnt=%0d lista=%b err=%b clave=%h st=%0d exp cnt=%0d lista=%b err=%b clave=%h st=%0d",
                 i, digitos_cnt, clave_lista, error_entrada, clave_ingresada, estado_dbg,
                 m_q.size(), m_lista, m_err, m_pin, m_state());
      end
      if (clave_lista === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL random_sb_unexpected got clave=%h exp no delivery", clave_ingresada);
        end else if (clave_ingresada !== exp_q[0]) begin
          errors++;
          $display("FAIL random_sb_pin got %h exp %h", clave_ingresada, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
      checks++;
      if (clave_lista === 1'b1 && error_entrada === 1'b1) begin
        errors++;
        $display("FAIL random_exclusive got lista=1 err=1 exp not both");
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_sb_leftover got %0d pending exp 0", exp_q.size());
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pin_ok();
    test_short_pin();
    test_extra_digit();
    test_borrar_timeout();
    test_hab_drop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
